pipe_stage_reg: RTL and testbench

Generic, parametrised pipeline stage register that replaces the fixed-field, always-advance segment registers between CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque payload of DATA_W bits under a valid/ready handshake.
- Supports stall (backpressure) and synchronous flush (branch/exception squash).
- Optional 2-entry skid mode registers the ready path to break long combinational stall chains.

---
 rtl/cpu_pipe_pkg.sv | 19 +
 rtl/pipe_stage_reg.sv | 116 +++++++++++
 tb/tb_pipe_stage_reg.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the CPU pipeline stage registers.
package cpu_pipe_pkg;

    // Stage occupancy states; the encoding doubles as the live-entry count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    localparam int unsigned OCC_W = 2;

    // Payload widths of the packed per-stage bundles.
    localparam int unsigned IF_ID_W  = 64;
    localparam int unsigned ID_EX_W  = 160;
    localparam int unsigned EX_MEM_W = 112;
    localparam int unsigned MEM_WB_W = 72;

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with optional 2-entry skid buffer and flush.
module pipe_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned SKID         = 0,
    parameter int unsigned CLR_ON_FLUSH = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]  occupancy
);

    stage_state_e      state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q;
    logic              push;
    logic              pop;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign occupancy = OCC_W'(state_q);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Next state and main-register load selection; flush overrides any push/pop.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (flush) begin
            state_d = ST_EMPTY;
            if (CLR_ON_FLUSH != 0) begin
                main_d = '0;
            end
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_d = ST_BUSY;
                        main_d  = in_data;
                    end
                end
                ST_BUSY: begin
                    if (push && pop) begin
                        main_d = in_data;
                    end else if (push && (SKID != 0)) begin
                        state_d = ST_FULL;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_d = ST_BUSY;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and main payload registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic rdy_q;

            // Skid entry captures the word accepted while the main entry is stalled.
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    skid_q <= '0;
                end else if (flush) begin
                    if (CLR_ON_FLUSH != 0) begin
                        skid_q <= '0;
                    end
                end else if ((state_q == ST_BUSY) && push && !pop) begin
                    skid_q <= in_data;
                end
            end

            // Registered ready cuts the out_ready -> in_ready chain.
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    rdy_q <= 1'b1;
                end else begin
                    rdy_q <= (state_d != ST_FULL);
                end
            end

            assign in_ready = resetn && rdy_q;
        end else begin : g_noskid
            assign skid_q   = '0;
            assign in_ready = resetn && (!out_valid || out_ready);
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized and directed bench for pipe_stage_reg in both skid and non-skid modes.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        rdy0, vld0, rdy1, vld1;
    logic [31:0] dat0, dat1;
    logic [1:0]  occ0, occ1;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: per DUT a FIFO of up to 2 words plus the last word shown at the output.
    int unsigned m_cnt   [2];
    logic [31:0] m_buf   [2][2];
    logic [31:0] m_shown [2];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .SKID(0), .CLR_ON_FLUSH(0)) u_noskid (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
        .out_valid(vld0), .out_ready(out_ready), .out_data(dat0),
        .occupancy(occ0)
    );

    pipe_stage_reg #(.DATA_W(32), .SKID(1), .CLR_ON_FLUSH(1)) u_skid (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .out_valid(vld1), .out_ready(out_ready), .out_data(dat1),
        .occupancy(occ1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive inputs at the falling edge, check both DUTs, advance the model.
    task automatic step(input logic rn, input logic fl, input logic iv,
                        input logic [31:0] d, input logic orr);
        resetn    = rn;
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        out_ready = orr;
        #1;
        for (int k = 0; k < 2; k++) begin
            logic        sk;
            logic        er;
            logic        ev;
            logic        push;
            logic        pop;
            logic        a_rdy;
            logic        a_vld;
            logic [31:0] a_dat;
            logic [1:0]  a_occ;
            sk    = (k == 1);
            a_rdy = sk ? rdy1 : rdy0;
            a_vld = sk ? vld1 : vld0;
            a_dat = sk ? dat1 : dat0;
            a_occ = sk ? occ1 : occ0;
            er    = rn && (sk ? (m_cnt[k] < 2) : ((m_cnt[k] == 0) || orr));
            ev    = (m_cnt[k] != 0);
            chk($sformatf("in_ready[skid=%0d]", k),  32'(a_rdy), 32'(er));
            chk($sformatf("out_valid[skid=%0d]", k), 32'(a_vld), 32'(ev));
            chk($sformatf("occupancy[skid=%0d]", k), 32'(a_occ), m_cnt[k]);
            chk($sformatf("out_data[skid=%0d]", k),  a_dat,      m_shown[k]);
            push = iv && er;
            pop  = ev && orr;
            if (!rn) begin
                m_cnt[k]   = 0;
                m_shown[k] = '0;
            end else if (fl) begin
                m_cnt[k] = 0;
                if (sk) m_shown[k] = '0;
            end else begin
                if (pop) begin
                    m_buf[k][0] = m_buf[k][1];
                    m_cnt[k]    = m_cnt[k] - 1;
                end
                if (push) begin
                    m_buf[k][m_cnt[k]] = d;
                    m_cnt[k]           = m_cnt[k] + 1;
                end
                if (m_cnt[k] != 0) m_shown[k] = m_buf[k][0];
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic orr, input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 32'h0, orr);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_cnt[k]    = 0;
            m_shown[k]  = '0;
            m_buf[k][0] = '0;
            m_buf[k][1] = '0;
        end
        resetn    = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset held with traffic offered, then release.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 32'hDEAD_0000 + 32'(i), 1'b1);
        idle(1'b0, 2);

        // Back-to-back streaming with the consumer always ready.
        step(1'b1, 1'b0, 1'b1, 32'h11, 1'b1);
        step(1'b1, 1'b0, 1'b1, 32'h22, 1'b1);
        step(1'b1, 1'b0, 1'b1, 32'h33, 1'b1);
        idle(1'b1, 2);

        // Stall: two pushes against a blocked consumer, then drain.
        step(1'b1, 1'b0, 1'b1, 32'hA, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'hB, 1'b0);
        idle(1'b0, 1);
        idle(1'b1, 3);

        // Long stall with a held word while upstream keeps offering.
        step(1'b1, 1'b0, 1'b1, 32'h55, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 32'h66, 1'b0);
        idle(1'b1, 3);

        // Flush from a stalled/full stage together with a new push.
        step(1'b1, 1'b0, 1'b1, 32'hA, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'hB, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'hC, 1'b0);
        idle(1'b1, 3);

        // Reset while full, then a single push.
        step(1'b1, 1'b0, 1'b1, 32'hA, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'hB, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h77, 1'b1);
        idle(1'b1, 3);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 59) != 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0, 32'($urandom), $urandom_range(0, 3) != 0);
        end
        idle(1'b1, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
